// File: rtl/ws2812_multi_capture.sv
// WS2812B multi-LED sniffer: captures the first NUM_LEDS*BYTES_PER_LED bytes of each frame and forwards the rest.
// `WS2812_PASSTHRU_EN enables forwarding of surplus bytes on dout; when it is undefined, dout is tied low.
module ws2812_multi_capture #(
  parameter int CLK_HZ           = 64000000,
  parameter int THRESHOLD_CYCLES = 38,
  parameter int IDLE_CYCLES      = 3840,
  parameter int NUM_LEDS         = 4,
  parameter int BYTES_PER_LED    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic       dout,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       frame_ready
);

  localparam int CAP = NUM_LEDS * BYTES_PER_LED;
  localparam int LW  = $clog2(IDLE_CYCLES + 1);
  localparam logic [7:0]    THR       = 8'(THRESHOLD_CYCLES);
  localparam logic [LW-1:0] IDLE_LAST = LW'(IDLE_CYCLES - 1);
  localparam logic [3:0]    CAP_W     = 4'(CAP);
  localparam logic [3:0]    CAP_LAST  = 4'(CAP - 1);

  generate
    if (CAP < 1 || CAP > 14 || CLK_HZ <= 0) begin : g_cap_check
      $error("ws2812_multi_capture: NUM_LEDS*BYTES_PER_LED must be within 1..14");
    end
  endgenerate

  typedef enum logic [1:0] {WAIT_IDLE, CAPTURE, FORWARD} state_t;

  state_t          state, state_n;
  logic            din_d;
  logic [7:0]      high_cnt;
  logic [LW-1:0]   low_cnt;
  logic            idle_hold;
  logic [6:0]      shift_reg;
  logic [2:0]      bit_cnt;
  logic [3:0]      byte_idx;
  logic [7:0]      cap_buf [CAP];
  logic            ready, ovf, short_flag;
  logic [3:0]      last_count;

  logic rise, fall, bit_val, idle_pulse, byte_done, cap_done;
  logic clr_ready, clr_ovf, clr_short, set_short;

  assign rise       = din & ~din_d;
  assign fall       = ~din & din_d;
  assign bit_val    = high_cnt > THR;
  assign idle_pulse = ~din & ~idle_hold & (low_cnt == IDLE_LAST);
  assign byte_done  = (state == CAPTURE) & fall & (bit_cnt == 3'd7);
  assign cap_done   = byte_done & (byte_idx == CAP_LAST);
  assign set_short  = idle_pulse & (state == CAPTURE) & (byte_idx != 4'd0) & (byte_idx < CAP_W);
  assign clr_ready  = data_write & (address == 4'hF) & data_in[0];
  assign clr_ovf    = data_write & (address == 4'hF) & data_in[1];
  assign clr_short  = data_write & (address == 4'hF) & data_in[2];

  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      WAIT_IDLE: if (idle_pulse) state_n = CAPTURE;
      CAPTURE: begin
        if (idle_pulse)    state_n = CAPTURE;
        else if (cap_done) state_n = FORWARD;
      end
      FORWARD:   if (idle_pulse) state_n = CAPTURE;
      default:   state_n = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      din_d      <= 1'b0;
      high_cnt   <= 8'd0;
      low_cnt    <= '0;
      idle_hold  <= 1'b0;
      shift_reg  <= 7'd0;
      bit_cnt    <= 3'd0;
      byte_idx   <= 4'd0;
      ready      <= 1'b0;
      ovf        <= 1'b0;
      short_flag <= 1'b0;
      last_count <= 4'd0;
      for (int i = 0; i < CAP; i++) cap_buf[i] <= 8'd0;
    end else begin
      din_d <= din;

      if (rise)                          high_cnt <= 8'd1;
      else if (din && high_cnt != 8'hFF) high_cnt <= high_cnt + 8'd1;

      // Idle fires once per low period; the hold clears only when din rises again.
      if (din) begin
        low_cnt   <= '0;
        idle_hold <= 1'b0;
      end else if (!idle_hold) begin
        if (idle_pulse) idle_hold <= 1'b1;
        else            low_cnt   <= low_cnt + 1'b1;
      end

      if (idle_pulse) begin
        bit_cnt    <= 3'd0;
        byte_idx   <= 4'd0;
        last_count <= byte_idx;
      end else if (state == CAPTURE && fall) begin
        shift_reg <= {shift_reg[5:0], bit_val};
        bit_cnt   <= bit_cnt + 3'd1;
        if (byte_done) begin
          cap_buf[byte_idx] <= {shift_reg, bit_val};
          byte_idx          <= byte_idx + 4'd1;
          if (cap_done) last_count <= CAP_W;
        end
      end

      ready      <= cap_done | (ready & ~clr_ready);
      ovf        <= (cap_done & ready) | (ovf & ~clr_ovf);
      short_flag <= set_short | (short_flag & ~clr_short);
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (address < CAP_W)       data_out = cap_buf[address];
    else if (address == 4'hE)  data_out = {last_count, 1'b0, short_flag, ovf, ready};
  end

  assign frame_ready = ready;

`ifdef WS2812_PASSTHRU_EN
  assign dout = (state == FORWARD) & din_d;
`else
  assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_multi_capture.sv
// Directed bench for ws2812_multi_capture: frame capture, forwarding, flags, reset abandon, decode threshold.
module tb_ws2812_multi_capture;

  logic       clk = 1'b0;
  logic       reset, din, data_write;
  logic [3:0] address;
  logic [7:0] data_in;
  logic       dout, frame_ready, dout2, frame_ready2;
  logic [7:0] data_out, data_out2;

`ifdef WS2812_PASSTHRU_EN
  localparam bit PASSTHRU = 1'b1;
`else
  localparam bit PASSTHRU = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  int pulse_q[$];
  int pulses_seen = 0;

  always #5 clk = ~clk;

  ws2812_multi_capture u_dut (
    .clk(clk), .reset(reset), .din(din), .dout(dout), .address(address),
    .data_write(data_write), .data_in(data_in), .data_out(data_out), .frame_ready(frame_ready)
  );

  ws2812_multi_capture #(.NUM_LEDS(3), .BYTES_PER_LED(4)) u_rgbw (
    .clk(clk), .reset(reset), .din(din), .dout(dout2), .address(address),
    .data_write(data_write), .data_in(data_in), .data_out(data_out2), .frame_ready(frame_ready2)
  );

  // dout monitor: each forwarded pulse must match a queued width and lag din by one cycle.
  int  cyc = 0, din_rise_cyc = 0, width = 0, exp_w;
  logic din_prev = 1'b0, dout_prev = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (din && !din_prev) din_rise_cyc = cyc;
    if (dout && !dout_prev) begin
      tests++;
      pulses_seen++;
      width = 0;
      assert ((cyc - din_rise_cyc) === 1) else begin
        fails++;
        $error("FAIL dout_delay: got %0d expected 1", cyc - din_rise_cyc);
      end
    end
    if (dout) width++;
    if (!dout && dout_prev) begin
      tests++;
      if (pulse_q.size() == 0) begin
        fails++;
        $error("FAIL dout_spurious: got pulse width %0d expected no pulse", width);
      end else begin
        exp_w = pulse_q.pop_front();
        assert (width === exp_w) else begin
          fails++;
          $error("FAIL dout_width: got %0d expected %0d", width, exp_w);
        end
      end
    end
    din_prev  = din;
    dout_prev = dout;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int h, input int l, input bit fwd);
    if (fwd && PASSTHRU) pulse_q.push_back(h);
    din = 1'b1; tick(h);
    din = 1'b0; tick(l);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit fwd, input bit cap);
    for (int i = 7; i >= 0; i--) begin
      if (b[i]) pulse(51, 29, fwd);
      else      pulse(26, 54, fwd);
    end
    if (cap) exp_q.push_back(b);
  endtask

  task automatic idle();
    din = 1'b0; tick(4000);
  endtask

  task automatic rd(input logic [3:0] a, input string tag, input logic [7:0] exp);
    address = a; #1;
    chk(tag, data_out, exp);
  endtask

  task automatic chk_frame(input string tag);
    logic [7:0] v;
    for (int a = 0; a < 12; a++) begin
      address = 4'(a); #1;
      v = exp_q.pop_front();
      chk(tag, data_out, v);
      chk({tag, "_rgbw"}, data_out2, v);
    end
  endtask

  task automatic ctrl_write(input logic [7:0] v);
    address = 4'hF; data_in = v; data_write = 1'b1;
    tick(1);
    data_write = 1'b0; data_in = 8'h00;
  endtask

  initial begin
    reset = 1'b1; din = 1'b0; data_write = 1'b0; address = 4'h0; data_in = 8'h00;
    tick(3);
    rd(4'hE, "reset_status", 8'h00);
    rd(4'h0, "reset_buf0", 8'h00);
    chk("reset_ready", {7'd0, frame_ready}, 8'h00);
    chk("reset_dout", {7'd0, dout}, 8'h00);
    reset = 1'b0;
    idle();

    // Full frame; last byte's final bit checks the one-cycle latency to frame_ready
    for (int i = 1; i <= 11; i++) send_byte(8'(i), 1'b0, 1'b1);
    for (int i = 7; i >= 1; i--) begin
      if (i == 3 || i == 2) pulse(51, 29, 1'b0);
      else                  pulse(26, 54, 1'b0);
    end
    din = 1'b1; tick(26);
    din = 1'b0;
    chk("ready_before_fall", {7'd0, frame_ready}, 8'h00);
    tick(1);
    chk("ready_after_fall", {7'd0, frame_ready}, 8'h01);
    exp_q.push_back(8'h0C);
    tick(53);
    idle();
    chk_frame("t1_buf");
    rd(4'hE, "t1_status", 8'hC1);
    chk("t1_ready", {7'd0, frame_ready}, 8'h01);

    // Second full frame plus surplus bytes; READY still set so OVF appears
    for (int i = 0; i < 12; i++) send_byte(8'h10 + 8'(i), 1'b0, 1'b1);
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'h55, 1'b1, 1'b0);
    idle();
    chk_frame("t2_buf");
    rd(4'hE, "t2_status_ovf", 8'hC3);
    chk("t2_pulses", 8'(pulses_seen), PASSTHRU ? 8'd16 : 8'd0);
    ctrl_write(8'h03);
    rd(4'hE, "t3_status_clr", 8'hC0);

    // Short frame: 5 bytes and 3 bits
    for (int i = 0; i < 5; i++) send_byte(8'hE0 + 8'(i), 1'b0, 1'b0);
    pulse(51, 29, 1'b0); pulse(26, 54, 1'b0); pulse(51, 29, 1'b0);
    idle();
    rd(4'hE, "t4_status_short", 8'h54);
    chk("t4_ready", {7'd0, frame_ready}, 8'h00);
    for (int i = 0; i < 12; i++) send_byte(8'h20 + 8'(i), 1'b0, 1'b1);
    idle();
    chk_frame("t4_buf");
    rd(4'hE, "t4_status_after", 8'hC5);

    // Reset mid-frame, then a frame without preceding idle is ignored
    for (int i = 0; i < 6; i++) send_byte(8'h77, 1'b0, 1'b0);
    reset = 1'b1; tick(2);
    rd(4'hE, "t5_status_reset", 8'h00);
    rd(4'h0, "t5_buf_reset", 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) send_byte(8'h99, 1'b0, 1'b0);
    rd(4'h0, "t5_no_capture", 8'h00);
    chk("t5_not_ready", {7'd0, frame_ready}, 8'h00);
    idle();
    rd(4'hE, "t5_status_idle", 8'h00);

    // Capture after idle; last byte built from 39/38-cycle boundary pulses
    for (int i = 0; i < 11; i++) send_byte(8'h30 + 8'(i), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      pulse(39, 41, 1'b0);
      pulse(38, 42, 1'b0);
    end
    exp_q.push_back(8'hAA);
    idle();
    chk_frame("t6_buf");
    rd(4'hC, "t6_addr_c", 8'h00);
    rd(4'hD, "t6_addr_d", 8'h00);
    address = 4'hD; #1;
    chk("t6_addr_d_rgbw", data_out2, 8'h00);
    rd(4'hF, "t6_addr_f", 8'h00);
    rd(4'hE, "t6_status", 8'hC1);
    chk("t6_ready_rgbw", {7'd0, frame_ready2}, 8'h01);
    chk("pulse_q_empty", 8'(pulse_q.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
